key_switch_device: RTL and testbench
====================================

# key_switch_device

Memory-mapped input responder for the push-buttons and slide switches, serving processor loads and stores on the data-memory/I-O bus. It synchronizes and debounces KEY and SW, holds the debounced values in data registers, and flags new-data and overrun status per device. Reads return data combinationally within the issuing cycle, as the single-cycle core requires. Status side effects take place on the following clock edge.

## Interface
- DBITS, 32, bus data/address width
- ADDR_KDATA, 32'hF0000010, debounced keys, read-only
- ADDR_SDATA, 32'hF0000014, debounced switches, read-only
- ADDR_KCTRL, 32'hF0000110, key status/control
- ADDR_SCTRL, 32'hF0000114, switch status/control
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required to accept a change (≥2)
- clk  in  1  system clock. The design uses one clock.
- reset  in  1  synchronous, active-high reset
- addr  in  DBITS  bus address
- rdEn  in  1  load strobe
- wrEn  in  1  store strobe
- wrData  in  DBITS  store data
- rdData  out  DBITS  load data, combinational. It is 0 when no register is addressed or rdEn=0.
- sel  out  1  high when addr matches any of the four registers
- KEY  in  4  raw buttons, active-low
- SW  in  10  raw switches, active-high

## Operation
- Raw inputs: KEY is inverted before use (pressed=1). Each of the 14 bits passes through a 2-flop synchronizer.
- Per-bit debounce:
  - A counter runs while the synced value differs from the debounced value. It clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bit still differing, the debounced bit takes the synced value on the next edge and the counter clears.
- KDATA[3:0] and SDATA[9:0] hold the debounced values. Upper bits read 0.
- CTRL register layout (KCTRL and SCTRL identical):
  - bit0 READY: set when any debounced bit of that device changes.
  - bit2 OVERRUN: set when a change occurs while READY=1 and no data read happens in the same cycle.
  - Other bits read 0.
- Clearing status:
  - A read of KDATA (rdEn and addr match) clears KREADY at the next edge. SDATA does the same for SREADY.
  - A store to CTRL with wrData[2]=0 clears OVERRUN. A store with wrData[2]=1 has no effect.
  - Stores to READY bits are ignored. Stores to DATA addresses are ignored.
- Simultaneous change event and DATA read in the same cycle: READY stays 1 and OVERRUN is unchanged, because the new data supersedes the old.
- Simultaneous change event and OVERRUN-clear store: OVERRUN ends at 1 if READY was 1, because the set wins.
- rdEn and wrEn both high to the same CTRL: the read returns the pre-edge value and the write applies at the edge.

## Timing
- Reset values, applied on the first edge with reset=1: synchronizers 0, counters 0, debounced data 0, READY 0, OVERRUN 0.
- Reset asserted mid-debounce discards the pending count.
- A switch already on at reset is accepted after normal latency and sets SREADY.
- Latency: a raw value stable from edge n appears in DATA and READY at edge n+2+DEBOUNCE_CYCLES.
- Glitch filtering: a glitch shorter than DEBOUNCE_CYCLES synced cycles never changes DATA.
- rdData and sel are combinational with zero latency. READY/OVERRUN reads reflect the state before the current edge.

## Configuration
- KEYSW_IRQ_EN defined:
  - Adds output irq (1 bit, registered, reset 0).
  - Adds IE at bit8 of each CTRL register, writable and reset 0.
  - irq is registered as (KREADY&KIE)|(SREADY&SIE), so it lags status by one cycle.
- KEYSW_IRQ_EN undefined: no irq port, and bit8 reads 0 and ignores writes.

## Structure
- Package io_pkg holds the four address constants, CTRL bit positions (READY=0, OVERRUN=2, IE=8), and the KEY/SW widths. This package is shared with the existing output devices.
- Sub-module debounce_bit contains the synchronizer, counter, and debounced flop, and outputs a one-cycle change pulse. The block instantiates it 14 times through generate.

## Test plan
- Reset, then idle KEY=4'hF, SW=0: reading 0xF0000010 returns 0 and reading 0xF0000110 returns 0.
- With DEBOUNCE_CYCLES=4, drive KEY[1]=0 at edge n: KDATA=0x2 and KCTRL=0x1 at edge n+6. A KDATA read then clears KCTRL to 0 at the next edge.
- Pulse SW[3] high for 3 cycles (DEBOUNCE_CYCLES=4): SDATA stays 0 and SCTRL stays 0.
- Two accepted SW changes with no read in between: SCTRL=0x5. Writing 0 to SCTRL gives 0x1. Reading SDATA gives 0x0.
- A change accepted on the same edge as a KDATA read: KCTRL=0x1 and OVERRUN=0.
- KEYSW_IRQ_EN: write KCTRL=0x100, then press KEY[0]: irq rises one cycle after KREADY, and falls one cycle after KDATA is read.

Source files
------------

// File: rtl/io_pkg.sv
// Shared I/O-bus definitions: register addresses, CTRL bit positions, input widths
// and the per-device status record used by the key/switch responder.
package io_pkg;

   localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
   localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
   localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
   localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;

   localparam int CTRL_READY   = 0;
   localparam int CTRL_OVERRUN = 2;
   localparam int CTRL_IE      = 8;

   localparam int KEY_W = 4;
   localparam int SW_W  = 10;

   typedef struct packed {
      logic ready;
      logic overrun;
      logic ie;
   } dev_status_t;

   function automatic logic [31:0] pack_ctrl(dev_status_t s);
      logic [31:0] c;
      c               = '0;
      c[CTRL_READY]   = s.ready;
      c[CTRL_OVERRUN] = s.overrun;
      c[CTRL_IE]      = s.ie;
      return c;
   endfunction

   // A change always wins: it re-arms READY over a data read and sets OVERRUN
   // over a clearing store. A read that coincides with a change suppresses OVERRUN.
   function automatic dev_status_t next_status(dev_status_t cur, logic chg, logic data_rd,
                                               logic ctrl_wr, logic wr_overrun, logic wr_ie);
      dev_status_t nxt;
      nxt = cur;
      if (ctrl_wr && !wr_overrun) nxt.overrun = 1'b0;
      if (chg && cur.ready && !data_rd) nxt.overrun = 1'b1;
      if (data_rd) nxt.ready = 1'b0;
      if (chg) nxt.ready = 1'b1;
      if (ctrl_wr) nxt.ie = wr_ie;
      return nxt;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, stability counter and debounced flop.
// change pulses for one cycle, in the cycle before the debounced value flips.
module debounce_bit #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic deb,
   output logic change
);

   logic        sync1;
   logic        sync2;
   logic [15:0] cnt;
   logic        differ;

   assign differ = (sync2 != deb);
   assign change = differ && (cnt == DEBOUNCE_CYCLES - 16'd1);

   // NOTE: state flops use non-blocking assignments so sync1->sync2 forms a true two-stage chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         deb   <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (!differ) begin
            cnt <= '0;
         end else if (change) begin
            deb <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/key_switch_device.sv
// Memory-mapped KEY/SW responder: debounced data registers plus READY/OVERRUN status.
// Build option KEYSW_IRQ_EN adds per-device interrupt enables and a registered irq output.
module key_switch_device
   import io_pkg::*;
#(
   parameter int          DBITS           = 32,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] addr,
   input  logic             rdEn,
   input  logic             wrEn,
   input  logic [DBITS-1:0] wrData,
   output logic [DBITS-1:0] rdData,
   output logic             sel,
   input  logic [KEY_W-1:0] KEY,
   input  logic [SW_W-1:0]  SW
`ifdef KEYSW_IRQ_EN
   ,
   output logic             irq
`endif
);

   localparam int NBITS = KEY_W + SW_W;

   logic [NBITS-1:0] raw;
   logic [NBITS-1:0] deb;
   logic [NBITS-1:0] chg;

   // Keys are active-low on the board; invert so pressed reads as 1.
   assign raw = {SW, ~KEY};

   for (genvar i = 0; i < NBITS; i++) begin : g_deb
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
         .clk    (clk),
         .reset  (reset),
         .raw    (raw[i]),
         .deb    (deb[i]),
         .change (chg[i])
      );
   end

   logic [KEY_W-1:0] key_data;
   logic [SW_W-1:0]  sw_data;
   logic             key_chg;
   logic             sw_chg;

   assign key_data = deb[KEY_W-1:0];
   assign sw_data  = deb[KEY_W +: SW_W];
   assign key_chg  = |chg[KEY_W-1:0];
   assign sw_chg   = |chg[KEY_W +: SW_W];

   logic hit_kdata, hit_sdata, hit_kctrl, hit_sctrl;

   assign hit_kdata = (addr == DBITS'(ADDR_KDATA));
   assign hit_sdata = (addr == DBITS'(ADDR_SDATA));
   assign hit_kctrl = (addr == DBITS'(ADDR_KCTRL));
   assign hit_sctrl = (addr == DBITS'(ADDR_SCTRL));
   assign sel       = hit_kdata | hit_sdata | hit_kctrl | hit_sctrl;

   dev_status_t k_stat, s_stat;
   dev_status_t k_next, s_next;
   logic        wr_ie;
   logic        unused_wr_bits;

`ifdef KEYSW_IRQ_EN
   assign wr_ie = wrData[CTRL_IE];
`else
   assign wr_ie = 1'b0;
`endif
   assign unused_wr_bits = ^wrData;

   assign k_next = next_status(k_stat, key_chg, rdEn && hit_kdata,
                               wrEn && hit_kctrl, wrData[CTRL_OVERRUN], wr_ie);
   assign s_next = next_status(s_stat, sw_chg, rdEn && hit_sdata,
                               wrEn && hit_sctrl, wrData[CTRL_OVERRUN], wr_ie);

   always_ff @(posedge clk) begin
      if (reset) begin
         k_stat <= '0;
         s_stat <= '0;
      end else begin
         k_stat <= k_next;
         s_stat <= s_next;
      end
   end

`ifdef KEYSW_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= (k_stat.ready & k_stat.ie) | (s_stat.ready & s_stat.ie);
   end
`endif

   // NOTE: default assigned first so every path drives rdData and no latch is inferred.
   always_comb begin
      rdData = '0;
      if (rdEn) begin
         if (hit_kdata)      rdData = DBITS'(key_data);
         else if (hit_sdata) rdData = DBITS'(sw_data);
         else if (hit_kctrl) rdData = DBITS'(pack_ctrl(k_stat));
         else if (hit_sctrl) rdData = DBITS'(pack_ctrl(s_stat));
      end
   end

endmodule

// File: tb/tb_key_switch_device.sv
// Directed bench for key_switch_device with a short debounce window (4 cycles).
module tb_key_switch_device;
   import io_pkg::*;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic [31:0] addr   = '0;
   logic        rdEn   = 1'b0;
   logic        wrEn   = 1'b0;
   logic [31:0] wrData = '0;
   logic [31:0] rdData;
   logic        sel;
   logic [3:0]  KEY    = 4'hF;
   logic [9:0]  SW     = '0;
`ifdef KEYSW_IRQ_EN
   logic        irq;
   localparam logic [31:0] IEV = 32'h100;
`else
   localparam logic [31:0] IEV = 32'h0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   key_switch_device #(.DBITS(32), .DEBOUNCE_CYCLES(16'd4)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .rdEn   (rdEn),
      .wrEn   (wrEn),
      .wrData (wrData),
      .rdData (rdData),
      .sel    (sel),
      .KEY    (KEY),
      .SW     (SW)
`ifdef KEYSW_IRQ_EN
      ,
      .irq    (irq)
`endif
   );

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Combinational read with no clock edge, so no side effects.
   task automatic peek(logic [31:0] a, logic [31:0] exp, string tag);
      addr = a;
      rdEn = 1'b1;
      #1;
      check(tag, rdData, exp);
      rdEn = 1'b0;
      addr = '0;
   endtask

   // Read held across a clock edge, so status side effects apply.
   task automatic consume(logic [31:0] a, logic [31:0] exp, string tag);
      addr = a;
      rdEn = 1'b1;
      #1;
      check(tag, rdData, exp);
      tick();
      rdEn = 1'b0;
      addr = '0;
   endtask

   task automatic store(logic [31:0] a, logic [31:0] d);
      addr   = a;
      wrData = d;
      wrEn   = 1'b1;
      tick();
      wrEn   = 1'b0;
      wrData = '0;
      addr   = '0;
   endtask

   initial begin
      // Reset and idle
      tick(2);
      reset = 1'b0;
      tick(3);
      peek(ADDR_KDATA, 32'h0, "reset_kdata");
      peek(ADDR_KCTRL, 32'h0, "reset_kctrl");
      peek(ADDR_SDATA, 32'h0, "reset_sdata");
      peek(ADDR_SCTRL, 32'h0, "reset_sctrl");

      // KEY[1] pressed: visible exactly 6 edges later
      KEY = 4'hD;
      tick(5);
      peek(ADDR_KDATA, 32'h0, "key_latency_early");
      tick();
      peek(ADDR_KDATA, 32'h2, "key_latency_data");
      peek(ADDR_KCTRL, 32'h1, "key_latency_ready");
      addr = ADDR_KDATA;
      #1;
      check("rd_disabled_zero", rdData, 32'h0);
      check("sel_kdata", {31'b0, sel}, 32'h1);
      addr = 32'hF000_0018;
      rdEn = 1'b1;
      #1;
      check("unmapped_zero", rdData, 32'h0);
      check("sel_unmapped", {31'b0, sel}, 32'h0);
      rdEn = 1'b0;
      consume(ADDR_KDATA, 32'h2, "kdata_read");
      peek(ADDR_KCTRL, 32'h0, "kready_cleared");

      // 3-cycle glitch on SW[3] is rejected
      SW = 10'h008;
      tick(3);
      SW = 10'h000;
      tick(10);
      peek(ADDR_SDATA, 32'h0, "glitch_sdata");
      peek(ADDR_SCTRL, 32'h0, "glitch_sctrl");

      // Two accepted switch changes without a read -> overrun
      SW = 10'h001;
      tick(6);
      peek(ADDR_SDATA, 32'h1, "sw_first_data");
      peek(ADDR_SCTRL, 32'h1, "sw_first_ctrl");
      SW = 10'h003;
      tick(6);
      peek(ADDR_SDATA, 32'h3, "sw_second_data");
      peek(ADDR_SCTRL, 32'h5, "sw_overrun");
      store(ADDR_SCTRL, 32'h4);
      peek(ADDR_SCTRL, 32'h5, "store_bit2_noclear");
      store(ADDR_SCTRL, 32'h0);
      peek(ADDR_SCTRL, 32'h1, "store_clear_overrun");
      store(ADDR_SDATA, 32'hFFFF);
      peek(ADDR_SDATA, 32'h3, "sdata_store_ignored");
      consume(ADDR_SDATA, 32'h3, "sdata_read");
      peek(ADDR_SCTRL, 32'h0, "sready_cleared");

      // Release KEY[1] so KREADY is set, then change coincides with a KDATA read
      KEY = 4'hF;
      tick(6);
      peek(ADDR_KDATA, 32'h0, "key_release_data");
      peek(ADDR_KCTRL, 32'h1, "key_release_ready");
      KEY = 4'hE;
      tick(5);
      addr = ADDR_KDATA;
      rdEn = 1'b1;
      tick();
      rdEn = 1'b0;
      addr = '0;
      peek(ADDR_KCTRL, 32'h1, "read_vs_change_ctrl");
      peek(ADDR_KDATA, 32'h1, "read_vs_change_data");

      // Change coincides with an OVERRUN-clear store while READY=1: set wins
      KEY = 4'hF;
      tick(5);
      store(ADDR_KCTRL, 32'h0);
      peek(ADDR_KCTRL, 32'h5, "clear_vs_change");
      store(ADDR_KCTRL, 32'h0);
      peek(ADDR_KCTRL, 32'h1, "kctrl_overrun_cleared");
      consume(ADDR_KDATA, 32'h0, "kdata_read2");
      peek(ADDR_KCTRL, 32'h0, "kctrl_idle");

      // Reset mid-debounce; switch held on through reset is accepted afterwards
      SW = 10'h007;
      tick(4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      peek(ADDR_SDATA, 32'h0, "midreset_sdata");
      peek(ADDR_SCTRL, 32'h0, "midreset_sctrl");
      tick(5);
      peek(ADDR_SDATA, 32'h0, "post_reset_early");
      tick();
      peek(ADDR_SDATA, 32'h7, "post_reset_data");
      peek(ADDR_SCTRL, 32'h1, "post_reset_sready");

      // Interrupt enable (bit8 reads 0 when the option is absent)
      store(ADDR_KCTRL, 32'h100);
      peek(ADDR_KCTRL, IEV, "kctrl_ie");
      KEY = 4'hE;
      tick(6);
      peek(ADDR_KCTRL, IEV | 32'h1, "irq_kready");
`ifdef KEYSW_IRQ_EN
      check("irq_lag_low", {31'b0, irq}, 32'h0);
      tick();
      check("irq_rise", {31'b0, irq}, 32'h1);
`else
      tick();
`endif
      consume(ADDR_KDATA, 32'h1, "irq_kdata_read");
      peek(ADDR_KCTRL, IEV, "irq_kready_cleared");
`ifdef KEYSW_IRQ_EN
      check("irq_still_high", {31'b0, irq}, 32'h1);
      tick();
      check("irq_fall", {31'b0, irq}, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
